// File: rtl/mcp_rx_settle_fifo.sv
// Settle filter and small FIFO on a clk2-registered multi-bit bus.
// A value is queued once it has been stable and differs from the last one queued.
module mcp_rx_settle_fifo #(
  parameter int WIDTH      = 8,
  parameter int STABLE_CNT = 2,
  parameter int DEPTH      = 4
) (
  input  logic                     clk2,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);

  typedef enum logic {
    HOLD,
    SETTLE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] last_acc;
  logic             eq;
  logic             qualify;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             full;
  logic             empty;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign eq = (data_in == prev_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qualify = 1'b0;
    unique case (state_q)
      HOLD: begin
        if (!eq) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!eq) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          qualify = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign push  = qualify && (prev_q != last_acc);
  assign pop   = out_valid && out_ready;
  // When full, a same-edge pop frees the slot being written.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      prev_q   <= '0;
      last_acc <= '0;
      state_q  <= HOLD;
      cnt_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      prev_q  <= data_in;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push)
        last_acc <= prev_q;
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk2) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= prev_q;
  end

  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign level     = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_mcp_rx_settle_fifo.sv
// Bench for mcp_rx_settle_fifo: run-length reference model,
// scoreboard queue and a negedge monitor, directed then random.
module tb_mcp_rx_settle_fifo;

  localparam int STABLE = 2;
  localparam int DEPTH  = 4;

  logic       clk2;
  logic       reset;
  logic [7:0] data_in;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] level;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_prev = 8'h00;
  logic [7:0] m_last = 8'h00;
  int         m_run   = 0;
  bit         m_armed = 1'b0;
  int         m_cnt   = 0;
  bit         m_ovf   = 1'b0;

  mcp_rx_settle_fifo #(
    .WIDTH(8),
    .STABLE_CNT(STABLE),
    .DEPTH(DEPTH)
  ) dut (
    .clk2(clk2),
    .reset(reset),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .level(level),
    .overflow(overflow)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Inputs change at posedge+1; the caller is always at posedge+1.
  task automatic step(input logic [7:0] d, input logic r, input int n);
    data_in   = d;
    out_ready = r;
    repeat (n) @(posedge clk2);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    data_in = 8'h00;
    repeat (2) @(posedge clk2);
    #1;
    reset = 1'b0;
  endtask

  // A run of samples that started with a change is accepted when it
  // reaches STABLE+1 samples; duplicates of the last accepted are dropped.
  task automatic model_edge();
    bit pop;
    bit qual;
    pop  = (m_cnt > 0) && out_ready;
    qual = 1'b0;
    if (data_in != m_prev) begin
      m_run   = 1;
      m_armed = 1'b1;
    end else if (m_armed) begin
      m_run++;
      if (m_run == STABLE + 1) begin
        qual    = 1'b1;
        m_armed = 1'b0;
      end
    end
    if (qual && data_in != m_last) begin
      m_last = data_in;
      if (m_cnt < DEPTH || pop) begin
        exp_q.push_back(data_in);
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (pop)
      m_cnt--;
    m_prev = data_in;
  endtask

  initial begin
    logic [7:0] v;
    int h;
    reset     = 1'b1;
    data_in   = 8'h00;
    out_ready = 1'b1;

    fork
      forever begin
        @(posedge clk2 or posedge reset);
        if (reset) begin
          m_prev  = 8'h00;
          m_last  = 8'h00;
          m_run   = 0;
          m_armed = 1'b0;
          m_cnt   = 0;
          m_ovf   = 1'b0;
          exp_q.delete();
        end else begin
          model_edge();
        end
      end
      forever begin
        @(negedge clk2);
        chk("valid", 32'(out_valid), 32'(m_cnt != 0));
        chk("level", 32'(level), m_cnt);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (m_cnt > 0 && exp_q.size() > 0) begin
          chk("head", 32'(out_data), 32'(exp_q[0]));
          if (out_ready)
            void'(exp_q.pop_front());
        end else begin
          chk("data_idle", 32'(out_data), 32'h0);
        end
      end
    join_none

    repeat (3) @(posedge clk2);
    #1;
    reset = 1'b0;

    step(8'h00, 1'b1, 20);
    chk("t1_level", 32'(level), 32'h0);
    chk("t1_valid", 32'(out_valid), 32'h0);
    chk("t1_ovf", 32'(overflow), 32'h0);

    step(8'h2A, 1'b0, 1);
    chk("t2_e0", 32'(out_valid), 32'h0);
    step(8'h2A, 1'b0, 1);
    chk("t2_e1", 32'(out_valid), 32'h0);
    step(8'h2A, 1'b0, 1);
    chk("t2_e2", 32'(out_valid), 32'h1);
    chk("t2_data", 32'(out_data), 32'h2A);
    chk("t2_level", 32'(level), 32'h1);
    step(8'h2A, 1'b0, 3);
    step(8'h2A, 1'b1, 2);

    step(8'h10, 1'b0, 1);
    step(8'h20, 1'b0, 6);
    step(8'h33, 1'b0, 1);
    step(8'h20, 1'b0, 6);
    chk("t3_level", 32'(level), 32'h1);
    chk("t3_data", 32'(out_data), 32'h20);
    step(8'h20, 1'b1, 2);
    chk("t3_drain", 32'(level), 32'h0);

    for (int i = 1; i <= 5; i++) begin
      step(8'(i), 1'b0, 4);
      if (i == 4) begin
        chk("t4_full", 32'(level), 32'h4);
        chk("t4_noovf", 32'(overflow), 32'h0);
      end
    end
    chk("t4_ovf", 32'(overflow), 32'h1);
    chk("t4_head", 32'(out_data), 32'h01);
    step(8'h05, 1'b1, 6);
    chk("t4_drain", 32'(level), 32'h0);
    chk("t4_sticky", 32'(overflow), 32'h1);

    do_reset();
    chk("rst_ovf", 32'(overflow), 32'h0);

    for (int i = 8'h11; i <= 8'h14; i++)
      step(8'(i), 1'b0, 4);
    chk("t5_full", 32'(level), 32'h4);
    step(8'h15, 1'b0, 2);
    step(8'h15, 1'b1, 1);
    chk("t5_level", 32'(level), 32'h4);
    chk("t5_ovf", 32'(overflow), 32'h0);
    chk("t5_head", 32'(out_data), 32'h12);
    step(8'h15, 1'b1, 6);
    chk("t5_drain", 32'(level), 32'h0);

    step(8'h41, 1'b0, 4);
    step(8'h42, 1'b0, 4);
    chk("t6_pre", 32'(level), 32'h2);
    step(8'h43, 1'b0, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_level", 32'(level), 32'h0);
    chk("t6_ovf", 32'(overflow), 32'h0);
    chk("t6_data", 32'(out_data), 32'h0);
    @(posedge clk2);
    #1;
    reset = 1'b0;
    step(8'h2A, 1'b0, 1);
    chk("t6_e0", 32'(out_valid), 32'h0);
    step(8'h2A, 1'b0, 1);
    chk("t6_e1", 32'(out_valid), 32'h0);
    step(8'h2A, 1'b0, 1);
    chk("t6_e2", 32'(out_valid), 32'h1);
    chk("t6_out", 32'(out_data), 32'h2A);
    step(8'h2A, 1'b1, 2);

    repeat (80) begin
      v = 8'($urandom_range(0, 3));
      h = $urandom_range(1, 5);
      repeat (h) step(v, 1'($urandom_range(0, 1)), 1);
    end
    step(data_in, 1'b1, 8);
    chk("end_level", 32'(level), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
